// File: rtl/avalon_mem_master.sv
`default_nettype none
// ============================================================================
// avalon_mem_master : single-access Avalon-MM master with command timeout
// Revision 1.0
// ============================================================================
module avalon_mem_master #(
  parameter int TIMEOUT_CYCLES    = 1023,
  parameter int USE_READDATAVALID = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] dataWrite,
  output logic [31:0] dataRead,
  output logic        done,
  output logic        error,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid
);

  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_CMD  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_CMD  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic [15:0] w_cnt_inc;

  assign w_cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = address & 32'hFFFF_FFFC;
          wdata_d = dataWrite;
          cnt_d   = 16'd0;
          if (read && !write) begin
            state_d = S_RD_CMD;
            rd_d    = 1'b1;
            err_d   = 1'b0;
          end else if (write && !read) begin
            state_d = S_WR_CMD;
            wr_d    = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      S_RD_CMD: begin
        cnt_d = w_cnt_inc;
        // An expiring timeout wins over a simultaneous accept
        if (w_cnt_inc == C_TIMEOUT) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (!avm_waitrequest) begin
          if (USE_READDATAVALID != 0) begin
            state_d = S_RD_DATA;
          end else begin
            rdata_d = avm_readdata;
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          rd_d = 1'b1;
        end
      end
      S_RD_DATA: begin
        cnt_d = w_cnt_inc;
        if (w_cnt_inc == C_TIMEOUT) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (avm_readdatavalid) begin
          rdata_d = avm_readdata;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_WR_CMD: begin
        cnt_d = w_cnt_inc;
        if (w_cnt_inc == C_TIMEOUT) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (!avm_waitrequest) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          wr_d = 1'b1;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
    be_d = (rd_d || wr_d) ? 4'b1111 : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= 16'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
    end
  end

  assign dataRead       = rdata_q;
  assign done           = done_q;
  assign error          = err_q;
  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_master.sv
`default_nettype none
// ============================================================================
// tb_avalon_mem_master : randomized transaction-level bench for avalon_mem_master
// Revision 1.0
// ============================================================================
module tb_avalon_mem_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset, start, read, write;
  logic [31:0] address, dataWrite, dataRead;
  logic        done, error;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [3:0]  avm_byteenable;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_rdata;

  avalon_mem_master #(
    .TIMEOUT_CYCLES   (TMO),
    .USE_READDATAVALID(1)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .read             (read),
    .write            (write),
    .address          (address),
    .dataWrite        (dataWrite),
    .dataRead         (dataRead),
    .done             (done),
    .error            (error),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_readdata     (avm_readdata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access with a slave that holds waitrequest for w command cycles and
  // returns readdatavalid d cycles after accept; expectations come from rules.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rv,
                        input int w, input int d, input bit drop, input int hold);
    int          k, j, bus, done_c, first_bus, exp_bus, exp_done_c;
    bit          accepted, exp_err;
    logic [31:0] exp_addr, exp_rd;
    exp_addr = {addr[31:2], 2'b00};
    exp_rd   = model_rdata;
    if (rd == wr) begin
      exp_bus = 0; exp_err = 1'b1; exp_done_c = 1;
    end else if (w + 1 >= TMO) begin
      exp_bus = TMO; exp_err = 1'b1; exp_done_c = TMO + 1;
    end else if (wr) begin
      exp_bus = w + 1; exp_err = 1'b0; exp_done_c = w + 2;
    end else if (w + 1 + d >= TMO) begin
      exp_bus = w + 1; exp_err = 1'b1; exp_done_c = TMO + 1;
    end else begin
      exp_bus = w + 1; exp_err = 1'b0; exp_done_c = w + d + 2; exp_rd = rv;
    end

    start = 1'b1; read = rd; write = wr; address = addr; dataWrite = wd;
    avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0;
    step();
    if (drop) start = 1'b0;
    address = $urandom; dataWrite = $urandom; read = 1'($urandom); write = 1'($urandom);

    k = 0; j = 0; bus = 0; done_c = 0; first_bus = 0; accepted = 1'b0;
    for (int c = 1; c <= 60 && done_c == 0; c++) begin
      if (done) begin
        done_c = c;
      end else begin
        if (avm_read || avm_write) begin
          bus++; k++;
          if (first_bus == 0) first_bus = c;
          chk("bus_type", 32'(avm_write), 32'(wr));
          chk("bus_addr", avm_address, exp_addr);
          chk("bus_be", 32'(avm_byteenable), 32'hF);
          if (wr) chk("bus_wdata", avm_writedata, wd);
          avm_waitrequest   = (k <= w);
          if (k > w) accepted = 1'b1;
          avm_readdatavalid = 1'($urandom);
          avm_readdata      = $urandom;
        end else begin
          avm_waitrequest = 1'b1;
          if (accepted && rd) begin
            j++;
            avm_readdatavalid = (j == d);
            avm_readdata      = (j == d) ? rv : $urandom;
          end else begin
            avm_readdatavalid = 1'b0;
          end
        end
        step();
      end
    end
    avm_readdatavalid = 1'b0;

    if (done_c == 0) begin
      chk("done_seen", 32'(done), 32'd1);
      reset = 1'b1; start = 1'b0;
      step();
      reset = 1'b0; model_rdata = 32'd0;
      return;
    end

    chk("bus_cycles", 32'(bus), 32'(exp_bus));
    chk("first_bus", 32'(first_bus), (rd == wr) ? 32'd0 : 32'd1);
    chk("done_cycle", 32'(done_c), 32'(exp_done_c));
    chk("error", 32'(error), 32'(exp_err));
    chk("dataRead", dataRead, exp_rd);
    chk("done_be", 32'(avm_byteenable), 32'd0);
    model_rdata = exp_rd;

    for (int h = 0; h < hold && !drop; h++) begin
      read = 1'($urandom); write = 1'($urandom);
      step();
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_bus", 32'(avm_read | avm_write), 32'd0);
    end
    start = 1'b0;
    step();
    chk("exit_done", 32'(done), 32'd0);
    chk("exit_err", 32'(error), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; read = 1'b0; write = 1'b0;
    address = 32'd0; dataWrite = 32'd0; avm_readdata = 32'd0;
    avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0; model_rdata = 32'd0;
    repeat (3) step();
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rd", 32'(avm_read), 32'd0);
    chk("rst_wr", 32'(avm_write), 32'd0);
    chk("rst_addr", avm_address, 32'd0);
    chk("rst_wdata", avm_writedata, 32'd0);
    chk("rst_rdata", dataRead, 32'd0);
    chk("rst_be", 32'(avm_byteenable), 32'd0);
    reset = 1'b0;
    step();

    access(1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'hCAFE_F00D, 0, 1, 1'b0, 0);
    access(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0, 3, 1, 1'b0, 0);
    access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h5555_AAAA, 20, 1, 1'b0, 0);
    access(1'b1, 1'b1, 32'h0000_0300, 32'h0, 32'h0, 0, 1, 1'b0, 2);
    access(1'b0, 1'b0, 32'h0000_0304, 32'h0, 32'h0, 0, 1, 1'b0, 0);
    access(1'b1, 1'b0, 32'h0000_0011, 32'h0, 32'h0BAD_BEEF, 1, 2, 1'b0, 10);
    access(1'b1, 1'b0, 32'h0000_0022, 32'h0, 32'h7777_0001, 2, 6, 1'b0, 0);
    access(1'b0, 1'b1, 32'h0000_0033, 32'hFEED_0001, 32'h0, 1, 1, 1'b1, 0);

    // Reset pulse while a write is stalled by waitrequest
    start = 1'b1; read = 1'b0; write = 1'b1; address = 32'h88; dataWrite = 32'hA5A5_A5A5;
    avm_waitrequest = 1'b1;
    step();
    step();
    chk("prerst_wr", 32'(avm_write), 32'd1);
    reset = 1'b1; start = 1'b0;
    step();
    chk("midrst_wr", 32'(avm_write), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(error), 32'd0);
    chk("midrst_addr", avm_address, 32'd0);
    chk("midrst_wdata", avm_writedata, 32'd0);
    chk("midrst_rdata", dataRead, 32'd0);
    reset = 1'b0; model_rdata = 32'd0;
    step();
    access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h1357_9BDF, 0, 1, 1'b0, 0);

    for (int t = 0; t < 60; t++) begin
      int sel;
      bit rd, wr;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        rd = 1'($urandom); wr = rd;
      end else begin
        rd = (sel < 5); wr = !rd;
      end
      access(rd, wr, $urandom, $urandom, $urandom, $urandom_range(0, 10),
             $urandom_range(1, 4), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
